multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Main controller of the multicycle MIPS datapath; drives the ALU from the control side.
//  Decodes Opcode/Funct into the 3-bit ALU_Control code and sequences fetch/decode/execute/mem/writeback.
//  Consumes ZERO_Flag from the ALU to resolve beq. One instruction in flight; 3-5 cycles per instruction.
// PARAMETERS
//  OPCODE_WIDTH      6  instruction [31:26] width
//  FUNCT_WIDTH       6  instruction [5:0] width
//  ALUControl_WIDTH  3  ALU operation code width
//  STATE_WIDTH       4  FSM state register width
// PORTS
//  CLK          in   1  clock, rising edge
//  RST          in   1  reset, asynchronous, active-low
//  Opcode       in   6  IR[31:26], valid from DECODE onward
//  Funct        in   6  IR[5:0]
//  ZERO_Flag    in   1  ALU result==0, combinational from ALU
//  ALU_Control  out  3  000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT
//  ALUSrcA      out  1  0 PC, 1 register A
//  ALUSrcB      out  2  00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  PCSrc        out  2  00 ALU_OUT, 01 ALUOut reg, 10 jump target
//  PCEn         out  1  PC load = PCWrite | (Branch & ZERO_Flag)
//  IorD         out  1  memory addr: 0 PC, 1 ALUOut
//  MemWrite     out  1  data memory write strobe
//  IRWrite      out  1  instruction register load
//  RegDst       out  1  0 rt, 1 rd
//  MemtoReg     out  1  0 ALUOut, 1 memory data
//  RegWrite     out  1  register file write strobe
//  State        out  4  current state (debug)
// BEHAVIOUR
//  - RST low: State=FETCH(0) immediately; PCEn, IRWrite, MemWrite, RegWrite forced 0 while RST low;
//    all other outputs take FETCH values. Reset mid-instruction aborts it; no write completes.
//  - Moore FSM, outputs decoded from State; only PCEn also depends on ZERO_Flag (same cycle, in BEQ).
//  - States/encodings: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 ALUWB7 BEQ8 ADDIEX9 ADDIWB10 JUMP11.
//  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALU ADD, PCSrc=00, IRWrite=1, PCEn=1 -> DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target). Next by Opcode:
//    100011 lw / 101011 sw -> MEMADR; 000000 R -> EXEC; 000100 beq -> BEQ;
//    001000 addi -> ADDIEX; 000010 j -> JUMP; any other -> FETCH (illegal, no side effects).
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: IorD=1 -> MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
//  - MEMWR: IorD=1, MemWrite=1 -> FETCH.
//  - EXEC: ALUSrcA=1, ALUSrcB=00, ALU_Control from Funct: 100000->010, 100010->100, 100100->000,
//    100101->001, 101010->110, 011000->101; unknown Funct -> 010 and flagged illegal (next FETCH,
//    no RegWrite). Legal -> ALUWB.
//  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH. ALU_Control held at EXEC value is not required.
//  - BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, Branch=1; PCEn=ZERO_Flag -> FETCH.
//  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
//  - JUMP: PCSrc=10, PCEn=1 -> FETCH.
//  - Default in all states: strobes 0, ALU_Control 010, mux selects 0. Unreachable State (12-15) -> FETCH.
//  - Latency (cycles incl. FETCH): lw 5, sw 4, R/addi 4, beq 3, j 3, illegal 2-3.
//  - Opcode/Funct sampled combinationally in DECODE/EXEC; IR must be stable after IRWrite.
// TESTING
//  - Reset: RST=0 mid-MEMWB -> State=0 at once, RegWrite=0, PCEn=0; release -> FETCH with IRWrite=1.
//  - lw (Opcode 100011): State 0,1,2,3,4,0; MEMWB has RegWrite=1, MemtoReg=1, RegDst=0.
//  - R-type sub (Funct 100010): EXEC shows ALU_Control=100; ALUWB RegWrite=1, RegDst=1; mul 011000 -> 101.
//  - beq with ZERO_Flag=1 -> PCEn=1, PCSrc=01 in BEQ; repeat with ZERO_Flag=0 -> PCEn=0.
//  - sw (101011): 0,1,2,5,0; MemWrite=1 exactly one cycle, RegWrite never asserted.
//  - Illegal Opcode 111111 and Funct 000001: return to FETCH, no RegWrite/MemWrite/PCEn outside FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Main controller for the multicycle MIPS datapath: a Moore FSM that sequences
// fetch/decode/execute/memory/writeback and decodes Opcode/Funct into ALU_Control.
module multicycle_control_unit #(
    parameter int OPCODE_WIDTH     = 6,
    parameter int FUNCT_WIDTH      = 6,
    parameter int ALUControl_WIDTH = 3,
    parameter int STATE_WIDTH      = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [OPCODE_WIDTH-1:0]     Opcode,
    input  logic [FUNCT_WIDTH-1:0]      Funct,
    input  logic                        ZERO_Flag,
    output logic [ALUControl_WIDTH-1:0] ALU_Control,
    output logic                        ALUSrcA,
    output logic [1:0]                  ALUSrcB,
    output logic [1:0]                  PCSrc,
    output logic                        PCEn,
    output logic                        IorD,
    output logic                        MemWrite,
    output logic                        IRWrite,
    output logic                        RegDst,
    output logic                        MemtoReg,
    output logic                        RegWrite,
    output logic [STATE_WIDTH-1:0]      State
);

    typedef enum logic [STATE_WIDTH-1:0] {
        FETCH   = STATE_WIDTH'(0),
        DECODE  = STATE_WIDTH'(1),
        MEMADR  = STATE_WIDTH'(2),
        MEMRD   = STATE_WIDTH'(3),
        MEMWB   = STATE_WIDTH'(4),
        MEMWR   = STATE_WIDTH'(5),
        EXEC    = STATE_WIDTH'(6),
        ALUWB   = STATE_WIDTH'(7),
        BEQ     = STATE_WIDTH'(8),
        ADDIEX  = STATE_WIDTH'(9),
        ADDIWB  = STATE_WIDTH'(10),
        JUMP    = STATE_WIDTH'(11)
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
    localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);

    localparam logic [FUNCT_WIDTH-1:0] FN_ADD = FUNCT_WIDTH'(6'b100000);
    localparam logic [FUNCT_WIDTH-1:0] FN_SUB = FUNCT_WIDTH'(6'b100010);
    localparam logic [FUNCT_WIDTH-1:0] FN_AND = FUNCT_WIDTH'(6'b100100);
    localparam logic [FUNCT_WIDTH-1:0] FN_OR  = FUNCT_WIDTH'(6'b100101);
    localparam logic [FUNCT_WIDTH-1:0] FN_SLT = FUNCT_WIDTH'(6'b101010);
    localparam logic [FUNCT_WIDTH-1:0] FN_MUL = FUNCT_WIDTH'(6'b011000);

    localparam logic [ALUControl_WIDTH-1:0] ALU_AND = ALUControl_WIDTH'(3'b000);
    localparam logic [ALUControl_WIDTH-1:0] ALU_OR  = ALUControl_WIDTH'(3'b001);
    localparam logic [ALUControl_WIDTH-1:0] ALU_ADD = ALUControl_WIDTH'(3'b010);
    localparam logic [ALUControl_WIDTH-1:0] ALU_SUB = ALUControl_WIDTH'(3'b100);
    localparam logic [ALUControl_WIDTH-1:0] ALU_MUL = ALUControl_WIDTH'(3'b101);
    localparam logic [ALUControl_WIDTH-1:0] ALU_SLT = ALUControl_WIDTH'(3'b110);

    state_t                        state_q;
    state_t                        state_d;
    logic [ALUControl_WIDTH-1:0]   funct_alu;
    logic                          funct_legal;
    logic                          pc_write;
    logic                          branch;
    logic                          ir_write;
    logic                          mem_write;
    logic                          reg_write;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // R-type function decode; an unknown Funct still drives ADD but aborts the instruction
    always_comb begin
        funct_alu   = ALU_ADD;
        funct_legal = 1'b1;
        case (Funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            FN_MUL:  funct_alu = ALU_MUL;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_d = MEMRD;
                end else if (Opcode == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = funct_legal ? ALUWB : FETCH;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode; write strobes are collected here and gated by reset below
    always_comb begin
        ALU_Control = ALU_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB  = 2'b01;
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                IorD = 1'b1;
            end
            MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
            end
            MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                ALUSrcA     = 1'b1;
                ALU_Control = funct_alu;
            end
            ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
            end
            BEQ: begin
                ALUSrcA     = 1'b1;
                ALU_Control = ALU_SUB;
                PCSrc       = 2'b01;
                branch      = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                ALU_Control = ALU_ADD;
            end
        endcase
    end

    // Strobes are masked by RST so nothing can be written while reset is held
    assign PCEn     = RST & (pc_write | (branch & ZERO_Flag));
    assign IRWrite  = RST & ir_write;
    assign MemWrite = RST & mem_write;
    assign RegWrite = RST & reg_write;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus pushes per-cycle expected
// output snapshots, a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

    logic       CLK;
    logic       RST;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       ZERO_Flag;
    logic [2:0] ALU_Control;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic [3:0] State;

    typedef struct {
        logic [18:0] val;
        logic [18:0] care;
        string       name;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] cur_exec_alu = 3'b010;

    multicycle_control_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .ZERO_Flag   (ZERO_Flag),
        .ALU_Control (ALU_Control),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSrc       (PCSrc),
        .PCEn        (PCEn),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .State       (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hand-written per-state output table; ALU_Control is a don't-care in ALUWB
    function automatic exp_t make_exp(input int st, input logic zero, input logic rst_low,
                                      input logic [2:0] exec_alu, input string nm);
        exp_t       e;
        logic [2:0] alu = 3'b010;
        logic [2:0] alu_care = 3'b111;
        logic       srca = 1'b0;
        logic [1:0] srcb = 2'b00;
        logic [1:0] pcsrc = 2'b00;
        logic       pcen = 1'b0, iord = 1'b0, mw = 1'b0, irw = 1'b0;
        logic       rd = 1'b0, mtr = 1'b0, rw = 1'b0;
        case (st)
            0:  begin srcb = 2'b01; irw = 1'b1; pcen = 1'b1; end
            1:  begin srcb = 2'b11; end
            2:  begin srca = 1'b1; srcb = 2'b10; end
            3:  begin iord = 1'b1; end
            4:  begin mtr = 1'b1; rw = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; end
            6:  begin srca = 1'b1; alu = exec_alu; end
            7:  begin rd = 1'b1; rw = 1'b1; alu_care = 3'b000; end
            8:  begin srca = 1'b1; alu = 3'b100; pcsrc = 2'b01; pcen = zero; end
            9:  begin srca = 1'b1; srcb = 2'b10; end
            10: begin rw = 1'b1; end
            11: begin pcsrc = 2'b10; pcen = 1'b1; end
            default: begin end
        endcase
        if (rst_low) begin
            pcen = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0;
        end
        e.val  = {4'(st), alu, srca, srcb, pcsrc, pcen, iord, mw, irw, rd, mtr, rw};
        e.care = {4'hF, alu_care, 12'hFFF};
        e.name = nm;
        return e;
    endfunction

    task automatic applyStimulus(input int st, input string nm);
        sb_q.push_back(make_exp(st, ZERO_Flag, !RST, cur_exec_alu, nm));
    endtask

    task automatic stepTo(input int st, input string nm);
        @(posedge CLK);
        #1;
        applyStimulus(st, nm);
    endtask

    // Called during a FETCH cycle; seq lists the states from DECODE back to FETCH
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                            input logic [2:0] exec_alu, input int seq[5], input int n,
                            input string nm);
        Opcode       = op;
        Funct        = fn;
        ZERO_Flag    = zero;
        cur_exec_alu = exec_alu;
        for (int i = 0; i < n; i++) begin
            stepTo(seq[i], $sformatf("%s_c%0d", nm, i + 1));
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [18:0] act;
        act = {State, ALU_Control, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite};
        checks++;
        if ((act & e.care) !== (e.val & e.care)) begin
            errors++;
            $display("[TB] FAIL %s: got %05h expected %05h (care %05h)", e.name, act, e.val, e.care);
        end
    endtask

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            checkOutput(sb_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST       = 1'b0;
        Opcode    = 6'b000000;
        Funct     = 6'b100000;
        ZERO_Flag = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        applyStimulus(0, "reset_hold");
        @(posedge CLK);
        #1;
        RST = 1'b1;
        applyStimulus(0, "reset_release");

        runInstr(6'b100011, 6'b000000, 1'b0, 3'b010, '{1, 2, 3, 4, 0}, 5, "lw");
        runInstr(6'b101011, 6'b000000, 1'b0, 3'b010, '{1, 2, 5, 0, 0}, 4, "sw");
        runInstr(6'b000000, 6'b100010, 1'b1, 3'b100, '{1, 6, 7, 0, 0}, 4, "sub");
        runInstr(6'b000000, 6'b011000, 1'b0, 3'b101, '{1, 6, 7, 0, 0}, 4, "mul");
        runInstr(6'b000000, 6'b100000, 1'b0, 3'b010, '{1, 6, 7, 0, 0}, 4, "add");
        runInstr(6'b000000, 6'b100100, 1'b0, 3'b000, '{1, 6, 7, 0, 0}, 4, "and");
        runInstr(6'b000000, 6'b100101, 1'b0, 3'b001, '{1, 6, 7, 0, 0}, 4, "or");
        runInstr(6'b000000, 6'b101010, 1'b0, 3'b110, '{1, 6, 7, 0, 0}, 4, "slt");
        runInstr(6'b000100, 6'b000000, 1'b1, 3'b010, '{1, 8, 0, 0, 0}, 3, "beq_taken");
        runInstr(6'b000100, 6'b000000, 1'b0, 3'b010, '{1, 8, 0, 0, 0}, 3, "beq_not_taken");
        runInstr(6'b001000, 6'b000000, 1'b0, 3'b010, '{1, 9, 10, 0, 0}, 4, "addi");
        runInstr(6'b000010, 6'b000000, 1'b0, 3'b010, '{1, 11, 0, 0, 0}, 3, "j");
        runInstr(6'b111111, 6'b000000, 1'b1, 3'b010, '{1, 0, 0, 0, 0}, 2, "ill_op");
        runInstr(6'b000000, 6'b000001, 1'b1, 3'b010, '{1, 6, 0, 0, 0}, 3, "ill_funct");

        // lw interrupted by reset while in MEMWB
        runInstr(6'b100011, 6'b000000, 1'b0, 3'b010, '{1, 2, 3, 0, 0}, 3, "lw_abort");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        applyStimulus(0, "reset_mid_memwb");
        stepTo(0, "reset_mid_hold");
        @(posedge CLK);
        #1;
        RST = 1'b1;
        applyStimulus(0, "reset_mid_release");
        runInstr(6'b000000, 6'b100010, 1'b0, 3'b100, '{1, 6, 7, 0, 0}, 4, "sub_after_reset");

        @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
